// File: rtl/table_pix_arb_if.sv
// Bus bundle for table_pix_arb: requester handshake, response strobe and glyph-lookup datapath.
// Carries req_lock_i only when TABLE_PIX_ARB_LOCK_EN is defined.
interface table_pix_arb_if #(
    parameter int REQ_CNT = 2,
    parameter int NUM_W   = 5,
    parameter int PIX_X_W = 12,
    parameter int PIX_Y_W = 12
);
    logic [REQ_CNT-1:0]         req_valid_i;
    logic [REQ_CNT-1:0]         req_ready_o;
    logic [REQ_CNT*NUM_W-1:0]   req_num_i;
    logic [REQ_CNT*PIX_X_W-1:0] req_x_i;
    logic [REQ_CNT*PIX_Y_W-1:0] req_y_i;
`ifdef TABLE_PIX_ARB_LOCK_EN
    logic [REQ_CNT-1:0]         req_lock_i;
`endif
    logic [REQ_CNT-1:0]         rsp_valid_o;
    logic                       rsp_pix_o;
    logic [NUM_W-1:0]           lut_num_o;
    logic [PIX_X_W-1:0]         lut_x_o;
    logic [PIX_Y_W-1:0]         lut_y_o;
    logic                       lut_pix_i;

`ifdef TABLE_PIX_ARB_LOCK_EN
    modport master (
        output req_valid_i, req_num_i, req_x_i, req_y_i, req_lock_i, lut_pix_i,
        input  req_ready_o, rsp_valid_o, rsp_pix_o, lut_num_o, lut_x_o, lut_y_o
    );

    modport slave (
        input  req_valid_i, req_num_i, req_x_i, req_y_i, req_lock_i, lut_pix_i,
        output req_ready_o, rsp_valid_o, rsp_pix_o, lut_num_o, lut_x_o, lut_y_o
    );
`else
    modport master (
        output req_valid_i, req_num_i, req_x_i, req_y_i, lut_pix_i,
        input  req_ready_o, rsp_valid_o, rsp_pix_o, lut_num_o, lut_x_o, lut_y_o
    );

    modport slave (
        input  req_valid_i, req_num_i, req_x_i, req_y_i, lut_pix_i,
        output req_ready_o, rsp_valid_o, rsp_pix_o, lut_num_o, lut_x_o, lut_y_o
    );
`endif
endinterface

// File: rtl/table_pix_arb.sv
// Round-robin arbiter sharing one fixed-latency glyph-pixel lookup among REQ_CNT requesters.
// Optional grant lock per requester is enabled by defining TABLE_PIX_ARB_LOCK_EN.
module table_pix_arb #(
    parameter int REQ_CNT = 2,
    parameter int NUM_CNT = 31,
    parameter int NUM_W   = $clog2(NUM_CNT),
    parameter int PIX_X_W = 12,
    parameter int PIX_Y_W = 12,
    parameter int LUT_LAT = 1
) (
    input logic            clk_i,
    input logic            rst_n_i,
    table_pix_arb_if.slave bus
);
    localparam int PTR_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic [PTR_W-1:0]   gnt_idx;
    logic [REQ_CNT-1:0] gnt;
    logic               hs;
    logic               lock_keep;
    logic [NUM_W-1:0]   gnt_num;
    logic [PIX_X_W-1:0] gnt_x;
    logic [PIX_Y_W-1:0] gnt_y;
    logic               gnt_oor;

    logic [NUM_W-1:0]   lut_num;
    logic [PIX_X_W-1:0] lut_x;
    logic [PIX_Y_W-1:0] lut_y;
    logic [REQ_CNT-1:0] rsp_valid;
    logic               rsp_pix;

    // Tag stages 0..LUT_LAT-1; the rsp_* registers form the final stage.
    logic [REQ_CNT-1:0] tag_id  [LUT_LAT];
    logic               tag_oor [LUT_LAT];

`ifdef TABLE_PIX_ARB_LOCK_EN
    logic [PTR_W-1:0]   last_id;
    logic               last_hs;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        lock_keep = 1'b0;
        hs        = |bus.req_valid_i;
        // Scan from the farthest offset down so the nearest valid requester at/after ptr wins.
        for (int i = REQ_CNT - 1; i >= 0; i--) begin
            if (bus.req_valid_i[(int'(ptr) + i) % REQ_CNT]) begin
                gnt_idx = PTR_W'((int'(ptr) + i) % REQ_CNT);
            end
        end
`ifdef TABLE_PIX_ARB_LOCK_EN
        if (last_hs && bus.req_valid_i[last_id] && bus.req_lock_i[last_id]) begin
            gnt_idx   = last_id;
            lock_keep = 1'b1;
        end
`endif
        gnt[gnt_idx] = hs;
    end

    always_comb begin
        gnt_num  = bus.req_num_i[gnt_idx*NUM_W +: NUM_W];
        gnt_x    = bus.req_x_i[gnt_idx*PIX_X_W +: PIX_X_W];
        gnt_y    = bus.req_y_i[gnt_idx*PIX_Y_W +: PIX_Y_W];
        gnt_oor  = 32'(gnt_num) >= 32'(NUM_CNT);
        ptr_next = ptr;
        if (hs && !lock_keep) begin
            ptr_next = (gnt_idx == PTR_W'(REQ_CNT - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge value of its neighbours.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr       <= '0;
            lut_num   <= '0;
            lut_x     <= '0;
            lut_y     <= '0;
            rsp_valid <= '0;
            rsp_pix   <= 1'b0;
            // NOTE: the tag pipeline is reset deliberately; a stale tag would produce a
            // phantom response after reset.
            for (int k = 0; k < LUT_LAT; k++) begin
                tag_id[k]  <= '0;
                tag_oor[k] <= 1'b0;
            end
`ifdef TABLE_PIX_ARB_LOCK_EN
            last_id   <= '0;
            last_hs   <= 1'b0;
`endif
        end else begin
            ptr <= ptr_next;
            if (hs) begin
                lut_num <= gnt_num;
                lut_x   <= gnt_x;
                lut_y   <= gnt_y;
            end
            tag_id[0]  <= gnt;
            tag_oor[0] <= hs & gnt_oor;
            for (int k = 1; k < LUT_LAT; k++) begin
                tag_id[k]  <= tag_id[k-1];
                tag_oor[k] <= tag_oor[k-1];
            end
            rsp_valid <= tag_id[LUT_LAT-1];
            rsp_pix   <= bus.lut_pix_i & ~tag_oor[LUT_LAT-1] & (|tag_id[LUT_LAT-1]);
`ifdef TABLE_PIX_ARB_LOCK_EN
            last_id   <= gnt_idx;
            last_hs   <= hs;
`endif
        end
    end

    assign bus.req_ready_o = gnt;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_pix_o   = rsp_pix;
    assign bus.lut_num_o   = lut_num;
    assign bus.lut_x_o     = lut_x;
    assign bus.lut_y_o     = lut_y;
endmodule

// File: tb/tb_table_pix_arb.sv
// Randomized self-checking bench for table_pix_arb against a queue-based reference model.
// Exercises the lock feature only when TABLE_PIX_ARB_LOCK_EN is defined.
module tb_table_pix_arb;
    localparam int REQ_CNT = 2;
    localparam int NUM_CNT = 31;
    localparam int NUM_W   = $clog2(NUM_CNT);
    localparam int PIX_X_W = 12;
    localparam int PIX_Y_W = 12;
    localparam int LUT_LAT = 1;
    localparam int SDEPTH  = 256;

    typedef struct {
        logic [NUM_W-1:0]   num;
        logic [PIX_X_W-1:0] x;
        logic [PIX_Y_W-1:0] y;
        logic               lock;
    } pay_t;

    typedef struct {
        int   due;
        int   id;
        logic pix;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_n_i;

    table_pix_arb_if #(
        .REQ_CNT(REQ_CNT), .NUM_W(NUM_W), .PIX_X_W(PIX_X_W), .PIX_Y_W(PIX_Y_W)
    ) bus ();

    table_pix_arb #(
        .REQ_CNT(REQ_CNT), .NUM_CNT(NUM_CNT), .NUM_W(NUM_W),
        .PIX_X_W(PIX_X_W), .PIX_Y_W(PIX_Y_W), .LUT_LAT(LUT_LAT)
    ) dut (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    // Glyph datapath stand-in; out-of-table indices read back as 1 to expose missing masking.
    function automatic logic glyph(logic [NUM_W-1:0] n, logic [PIX_X_W-1:0] x, logic [PIX_Y_W-1:0] y);
        if (int'(n) >= NUM_CNT) return 1'b1;
        return ((int'(n) * 7 + int'(x) * 3 + int'(y)) % 5) < 2;
    endfunction

    assign bus.lut_pix_i = glyph(bus.lut_num_o, bus.lut_x_o, bus.lut_y_o);

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_rsp    = 0;
    pay_t sbuf [REQ_CNT][SDEPTH];
    int   s_rd [REQ_CNT];
    int   s_wr [REQ_CNT];
    exp_t exp_q[$];
    int   m_ptr;
    int   m_last;
    logic m_last_hs;
    pay_t m_lut;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic bit has_req(int k);
        return s_wr[k] != s_rd[k];
    endfunction

    function automatic pay_t head(int k);
        return sbuf[k][s_rd[k] % SDEPTH];
    endfunction

    task automatic push(input int k, input logic [NUM_W-1:0] num, input logic [PIX_X_W-1:0] x,
                        input logic [PIX_Y_W-1:0] y, input logic lock);
        pay_t p;
        p.num = num; p.x = x; p.y = y; p.lock = lock;
        sbuf[k][s_wr[k] % SDEPTH] = p;
        s_wr[k]++;
    endtask

    task automatic push_rand(input int k, input int oor_pct);
        logic [NUM_W-1:0] n;
        n = NUM_W'($urandom_range(NUM_CNT - 1, 0));
        if ($urandom_range(99, 0) < oor_pct) n = NUM_W'(NUM_CNT);
        push(k, n, PIX_X_W'($urandom), PIX_Y_W'($urandom), 1'b0);
    endtask

    // Reference arbitration: first valid requester at or after the pointer, unless the
    // previous winner still asserts valid and lock.
    function automatic int model_grant();
`ifdef TABLE_PIX_ARB_LOCK_EN
        if (m_last_hs && has_req(m_last) && head(m_last).lock) return m_last;
`endif
        for (int i = 0; i < REQ_CNT; i++) begin
            if (has_req((m_ptr + i) % REQ_CNT)) return (m_ptr + i) % REQ_CNT;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_last = 0; m_last_hs = 1'b0;
        m_lut.num = '0; m_lut.x = '0; m_lut.y = '0; m_lut.lock = 1'b0;
        exp_q.delete();
        for (int k = 0; k < REQ_CNT; k++) s_rd[k] = s_wr[k];
    endtask

    task automatic drive();
        for (int k = 0; k < REQ_CNT; k++) begin
            pay_t p;
            p = head(k);
            if (!has_req(k)) begin
                p.num = '0; p.x = '0; p.y = '0; p.lock = 1'b0;
            end
            bus.req_valid_i[k]                      = has_req(k);
            bus.req_num_i[k*NUM_W +: NUM_W]         = p.num;
            bus.req_x_i[k*PIX_X_W +: PIX_X_W]       = p.x;
            bus.req_y_i[k*PIX_Y_W +: PIX_Y_W]       = p.y;
`ifdef TABLE_PIX_ARB_LOCK_EN
            bus.req_lock_i[k]                       = p.lock;
`endif
        end
    endtask

    task automatic check_outputs();
        logic [REQ_CNT-1:0] ev;
        logic               ep;
        exp_t               e;
        ev = '0; ep = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e  = exp_q.pop_front();
            ev = REQ_CNT'(1) << e.id;
            ep = e.pix;
            n_rsp++;
        end
        check("rsp_valid", 64'(bus.rsp_valid_o), 64'(ev));
        if (ev != '0) check("rsp_pix", 64'(bus.rsp_pix_o), 64'(ep));
        check("lut_num", 64'(bus.lut_num_o), 64'(m_lut.num));
        check("lut_x", 64'(bus.lut_x_o), 64'(m_lut.x));
        check("lut_y", 64'(bus.lut_y_o), 64'(m_lut.y));
    endtask

    task automatic cycle();
        int   g;
        pay_t p;
        exp_t e;
        @(negedge clk_i);
        cyc++;
        check_outputs();
        drive();
        #1;
        g = model_grant();
        check("ready", 64'(bus.req_ready_o), (g >= 0) ? (64'd1 << g) : 64'd0);
        if (g >= 0) begin
            p = head(g);
            s_rd[g]++;
            e.due = cyc + 1 + LUT_LAT;
            e.id  = g;
            e.pix = glyph(p.num, p.x, p.y) & (int'(p.num) < NUM_CNT);
            exp_q.push_back(e);
            m_lut = p;
            if (!(m_last_hs && g == m_last && p.lock)) m_ptr = (g + 1) % REQ_CNT;
        end
        m_last_hs = (g >= 0);
        if (g >= 0) m_last = g;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || has_req(0) || has_req(1)) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk_i);
        cyc++;
        check_outputs();
        rst_n_i = 1'b0;
        model_reset();
        drive();
        #1;
        check("rst_ready", 64'(bus.req_ready_o), 64'd0);
        check("rst_lut_num", 64'(bus.lut_num_o), 64'd0);
        repeat (hold) begin
            @(negedge clk_i);
            cyc++;
            check_outputs();
        end
        rst_n_i = 1'b1;
    endtask

    initial begin
        int base;
        int n;
        rst_n_i = 1'b0;
        bus.req_valid_i = '0;
        bus.req_num_i   = '0;
        bus.req_x_i     = '0;
        bus.req_y_i     = '0;
`ifdef TABLE_PIX_ARB_LOCK_EN
        bus.req_lock_i  = '0;
`endif
        for (int k = 0; k < REQ_CNT; k++) begin s_rd[k] = 0; s_wr[k] = 0; end
        model_reset();

        // Reset state and 20 idle cycles after release.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("reset_rsp_pix", 64'(bus.rsp_pix_o), 64'd0);
        check("reset_ready", 64'(bus.req_ready_o), 64'd0);
        rst_n_i = 1'b1;
        repeat (20) cycle();

        // Lone requester streaming num=3, x=5..9.
        base = n_rsp;
        for (int i = 0; i < 5; i++) push(0, NUM_W'(3), PIX_X_W'(5 + i), '0, 1'b0);
        drain(20);
        check("single_rsp_count", 64'(n_rsp - base), 64'd5);

        // Both requesters continuously valid: strict alternation, no loss.
        base = n_rsp;
        for (int i = 0; i < 50; i++) begin push_rand(0, 0); push_rand(1, 0); end
        drain(200);
        check("fair_rsp_count", 64'(n_rsp - base), 64'd100);

        // Out-of-range glyph index: datapath returns 1, response must be 0.
        base = n_rsp;
        push(1, NUM_W'(NUM_CNT), PIX_X_W'(7), PIX_Y_W'(2), 1'b0);
        drain(10);
        check("oor_rsp_count", 64'(n_rsp - base), 64'd1);

        // Random traffic with gaps and occasional out-of-range indices.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < REQ_CNT; k++) begin
                if (!has_req(k) && $urandom_range(99, 0) < 60) push_rand(k, 10);
            end
            cycle();
        end
        drain(20);

        // Reset the cycle after a handshake: the in-flight response must vanish.
        push(1, NUM_W'(4), PIX_X_W'(1), PIX_Y_W'(1), 1'b0);
        n = 0;
        while (has_req(1) && n < 4) begin cycle(); n++; end
        check("midflight_accepted", 64'(has_req(1)), 64'd0);
        do_reset(2);
        push(0, NUM_W'(2), '0, '0, 1'b0);
        push(1, NUM_W'(6), '0, '0, 1'b0);
        cycle();
        check("post_rst_grant0", 64'(s_rd[0] - s_wr[0] + 1), 64'd1);
        drain(20);

`ifdef TABLE_PIX_ARB_LOCK_EN
        // Requester 1 locks four consecutive grants while requester 0 waits.
        push(1, NUM_W'(8), PIX_X_W'(0), '0, 1'b1);
        push(1, NUM_W'(8), PIX_X_W'(1), '0, 1'b1);
        push(1, NUM_W'(8), PIX_X_W'(2), '0, 1'b1);
        push(1, NUM_W'(8), PIX_X_W'(3), '0, 1'b1);
        for (int i = 0; i < 5; i++) push(0, NUM_W'(9), PIX_X_W'(i), '0, 1'b0);
        drain(40);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/table_pix_arb.md
# table_pix_arb

Round-robin arbiter that shares one glyph-pixel lookup datapath (number index plus x/y position in, 1-bit pixel out, fixed read latency) between `REQ_CNT` pixel requesters, e.g. the calendar-table renderer and the clock-digit renderer. It accepts at most one lookup per cycle. It tracks in-flight lookups through the datapath latency and returns each pixel to the requester that issued it. Requests with out-of-range numbers are answered locally with a 0 pixel.

## Interface
- `REQ_CNT`, 2, number of requesters (2..8)
- `NUM_CNT`, 31, number of glyphs in the lookup table
- `NUM_W`, `$clog2(NUM_CNT)`, glyph index width
- `PIX_X_W`, 12, x position width
- `PIX_Y_W`, 12, y position width
- `LUT_LAT`, 1, cycles from `lut_*_o` change to valid `lut_pix_i` (1..4)

- `clk_i`  in  1  single clock
- `rst_n_i`  in  1  asynchronous, active-low reset
- `req_valid_i`  in  REQ_CNT  per-requester request
- `req_ready_o`  out  REQ_CNT  one-hot grant; handshake when valid&ready
- `req_num_i`  in  REQ_CNT*NUM_W  packed glyph index, requester k at [k*NUM_W +: NUM_W]
- `req_x_i`  in  REQ_CNT*PIX_X_W  packed x position
- `req_y_i`  in  REQ_CNT*PIX_Y_W  packed y position
- `rsp_valid_o`  out  REQ_CNT  one-hot response strobe
- `rsp_pix_o`  out  1  pixel for the strobed requester
- `lut_num_o`  out  NUM_W  registered glyph index to datapath
- `lut_x_o`  out  PIX_X_W  registered x to datapath
- `lut_y_o`  out  PIX_Y_W  registered y to datapath
- `lut_pix_i`  in  1  datapath pixel

## Operation
- **Arbitration** is combinational from `req_valid_i` and the round-robin pointer `ptr`.
  - Grant goes to the first valid requester at or after `ptr`, wrapping modulo `REQ_CNT`.
  - `req_ready_o` is all-zero when no requester is valid.
  - Only the granted bit of `req_ready_o` is ever high.
- **Pointer update:** on a handshake by requester g, `ptr` ← (g+1) mod `REQ_CNT`. With no handshake, `ptr` holds.
- **Requester rule:** a requester holds valid and payload stable until ready. The arbiter never stalls, so a lone requester is granted every cycle.
- **Issue stage:** on a handshake, `lut_num_o`/`lut_x_o`/`lut_y_o` register the granted payload. A tag pipeline of depth `1+LUT_LAT` records the one-hot requester id and an out-of-range flag (`req_num >= NUM_CNT`). With no handshake, the `lut_*` outputs hold and a null tag is inserted.
- **Out-of-range requests:** the index is still driven to the datapath. The response pixel is forced to 0.
- **Response:** when the tag reaches the end of the pipeline:
  - `rsp_valid_o` ← tag id, registered.
  - `rsp_pix_o` ← `lut_pix_i` & !oor.
  - `rsp_valid_o` is high for exactly one cycle. There is no response backpressure; requesters must always accept.
- **In-order delivery:** responses come back in issue order with one response per accepted request. No request is dropped or duplicated.

## Timing
- **Reset values:** `req_ready_o` is combinational (0 while all valid low). `rsp_valid_o`=0, `rsp_pix_o`=0, `lut_*_o`=0, `ptr`=0, tag pipeline cleared.
- **Latency:** for a handshake in cycle T:
  - `lut_*_o` are valid in T+1.
  - `lut_pix_i` is sampled at the end of T+LUT_LAT.
  - `rsp_valid_o` is high in cycle T+1+LUT_LAT, which is 2 cycles with the default.
- **Throughput:** 1 lookup per cycle, back-to-back, across any mix of requesters.
- **Reset mid-operation:** asserting `rst_n_i` immediately clears all in-flight tags. No response is produced for requests accepted before reset.
- **Wrap-around:** `ptr` at `REQ_CNT-1` with requester `REQ_CNT-1` granted wraps to 0.

## Configuration
- `TABLE_PIX_ARB_LOCK_EN`
  - **Defined:** adds port `req_lock_i` (in, `REQ_CNT`). While the requester granted last cycle keeps valid and lock both high, it keeps the grant and `ptr` does not advance. This lets a renderer complete a glyph row uninterrupted. When that requester drops lock or valid, normal round-robin resumes from (holder+1).
  - **Undefined:** the port is absent and arbitration is pure round-robin.

## Test plan
- **Reset check:** with `rst_n_i`=0, then release with all valid low → all outputs 0, no `rsp_valid_o` for 20 cycles.
- **Single requester:** requester 0 streams num=3, x=5..9, y=0 for 5 consecutive cycles → ready high every cycle. `lut_*` follow one cycle later. Five `rsp_valid_o`=01 strobes, each 2 cycles after its handshake, with pixels matching the model.
- **Fair sharing:** both requesters continuously valid → grants alternate 0,1,0,1. Responses alternate in the same order, with no loss over 100 requests.
- **Out-of-range:** requester 1 sends num=31 (`NUM_CNT`=31) → `rsp_valid_o`=10, `rsp_pix_o`=0 even when `lut_pix_i`=1.
- **Reset mid-flight:** assert `rst_n_i` the cycle after a handshake → no response strobe appears; the first post-reset grant goes to requester 0.
- **Lock (`TABLE_PIX_ARB_LOCK_EN`):** requester 1 holds lock for 4 requests while requester 0 is valid → 4 consecutive grants to 1, then requester 0 is granted next.
